// File: rtl/ram_bist_pkg.sv
// Shared types and the March C- element table for the RAM BIST controller.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CW,
        ST_DONE
    } bist_state_t;

    localparam int unsigned NUM_ELEM = 6;
    localparam int unsigned ELEM_W   = 3;

    typedef struct packed {
        logic down;
        logic has_read;
        logic read_val;
        logic has_write;
        logic write_val;
    } march_elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) dn(r0)
    localparam march_elem_t MARCH_TABLE [NUM_ELEM] = '{
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
    };

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter; o_last flags the final address of the sweep.
module ram_bist_addr_gen #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_en,
    input  logic              i_down,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_en) begin
            r_addr <= i_down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller driving a single-port synchronous RAM; stops on first miscompare.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       ADDR_W = 8,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_exp,
    output logic [DATA_W-1:0] o_fail_got,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam logic [DATA_W-1:0] D0        = BG;
    localparam logic [DATA_W-1:0] D1        = ~BG;
    localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(NUM_ELEM - 1);

    bist_state_t       r_state, w_state_nxt;
    logic [ELEM_W-1:0] r_elem, w_elem_nxt, w_elem_inc;
    march_elem_t       w_cur;
    logic              w_nxt_down;

    logic              r_busy, r_done, r_pass, r_we;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_exp, r_fail_got, r_wdata;

    logic              w_ag_load, w_ag_en, w_last;
    logic [ADDR_W-1:0] w_ag_load_val, w_addr;
    logic [DATA_W-1:0] w_exp, w_wdata_nxt;
    logic              w_mismatch, w_we_nxt, w_start_run, w_finish, w_finish_pass;

    ram_bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_ag_load),
        .i_load_val (w_ag_load_val),
        .i_en       (w_ag_en),
        .i_down     (w_cur.down),
        .o_addr     (w_addr),
        .o_last     (w_last)
    );

    always_comb begin
        w_cur         = MARCH_TABLE[r_elem];
        w_elem_inc    = r_elem + ELEM_W'(1);
        w_nxt_down    = (r_elem < LAST_ELEM) ? MARCH_TABLE[w_elem_inc].down : 1'b0;
        w_exp         = w_cur.read_val ? D1 : D0;
        w_mismatch    = (r_state == ST_CW) && w_cur.has_read && (i_ram_rdata != w_exp);

        w_state_nxt   = r_state;
        w_elem_nxt    = r_elem;
        w_ag_load     = 1'b0;
        w_ag_load_val = '0;
        w_ag_en       = 1'b0;
        w_we_nxt      = 1'b0;
        w_wdata_nxt   = r_wdata;
        w_start_run   = 1'b0;
        w_finish      = 1'b0;
        w_finish_pass = 1'b0;

        // Next-cycle RAM controls are registered alongside the state they belong to.
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_start_run = 1'b1;
                    w_state_nxt = ST_WR;
                    w_elem_nxt  = '0;
                    w_ag_load   = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = D0;
                end
            end
            ST_WR: begin
                if (w_last) begin
                    w_state_nxt   = ST_RD;
                    w_elem_nxt    = w_elem_inc;
                    w_ag_load     = 1'b1;
                    w_ag_load_val = {ADDR_W{w_nxt_down}};
                end else begin
                    w_ag_en     = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = D0;
                end
            end
            ST_RD: begin
                w_state_nxt = ST_CW;
                w_we_nxt    = w_cur.has_write;
                w_wdata_nxt = w_cur.write_val ? D1 : D0;
            end
            ST_CW: begin
                if (w_mismatch) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end else if (!w_last) begin
                    w_state_nxt = ST_RD;
                    w_ag_en     = 1'b1;
                end else if (r_elem != LAST_ELEM) begin
                    w_state_nxt   = ST_RD;
                    w_elem_nxt    = w_elem_inc;
                    w_ag_load     = 1'b1;
                    w_ag_load_val = {ADDR_W{w_nxt_down}};
                end else begin
                    w_state_nxt   = ST_DONE;
                    w_finish      = 1'b1;
                    w_finish_pass = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_elem      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
            if (w_start_run) begin
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_exp  <= '0;
                r_fail_got  <= '0;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= w_finish_pass;
                if (w_mismatch) begin
                    r_fail_addr <= w_addr;
                    r_fail_exp  <= w_exp;
                    r_fail_got  <= i_ram_rdata;
                end
            end
        end
    end

    // Write is vetoed on a miscompare; i_ram_rdata comes from a clocked RAM, so this still moves only on clk edges.
    assign o_ram_we    = r_we & ~w_mismatch;
    assign o_ram_addr  = w_addr;
    assign o_ram_wdata = r_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_exp  = r_fail_exp;
    assign o_fail_got  = r_fail_got;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (BG = 0 and BG = 5555_5555) on faultable RAM models.
module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s  [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic        pass_s   [2];
    logic [2:0]  faddr_s  [2];
    logic [31:0] fexp_s   [2];
    logic [31:0] fgot_s   [2];
    logic [2:0]  addr_s   [2];
    logic        we_s     [2];
    logic [31:0] wd_s     [2];
    logic [31:0] rd_s     [2];

    int checks = 0;
    int errors = 0;

    // fault config: 0 none, 1 cell f_a bit f_bit stuck at f_val, 2 write to f_a also writes f_b
    int          f_mode = 0;
    logic [2:0]  f_a = '0, f_b = '0;
    int          f_bit = 0;
    logic        f_val = 1'b0;

    logic [31:0] mem [2][8];
    int          cap_sel = 0;
    logic [34:0] wr_q[$];
    logic [34:0] exp_wr[$];

    bit          m_pass;
    logic [2:0]  m_faddr;
    logic [31:0] m_fexp, m_fgot;
    int          m_cyc;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.DATA_W(32), .ADDR_W(3), .BG(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start_s[0]), .o_busy(busy_s[0]), .o_done(done_s[0]),
        .o_pass(pass_s[0]), .o_fail_addr(faddr_s[0]), .o_fail_exp(fexp_s[0]), .o_fail_got(fgot_s[0]),
        .o_ram_addr(addr_s[0]), .o_ram_we(we_s[0]), .o_ram_wdata(wd_s[0]), .i_ram_rdata(rd_s[0]));

    ram_bist_ctrl #(.DATA_W(32), .ADDR_W(3), .BG(32'h5555_5555)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start_s[1]), .o_busy(busy_s[1]), .o_done(done_s[1]),
        .o_pass(pass_s[1]), .o_fail_addr(faddr_s[1]), .o_fail_exp(fexp_s[1]), .o_fail_got(fgot_s[1]),
        .o_ram_addr(addr_s[1]), .o_ram_we(we_s[1]), .o_ram_wdata(wd_s[1]), .i_ram_rdata(rd_s[1]));

    function automatic logic [31:0] cell_read(input logic [2:0] a, input logic [31:0] v);
        logic [31:0] mask;
        mask = 32'h1 << f_bit;
        if (f_mode == 1 && a == f_a) return f_val ? (v | mask) : (v & ~mask);
        return v;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (we_s[g]) begin
                mem[g][addr_s[g]] <= wd_s[g];
                if (f_mode == 2 && addr_s[g] == f_a) mem[g][f_b] <= wd_s[g];
            end
            rd_s[g] <= cell_read(addr_s[g], mem[g][addr_s[g]]);
        end
    end

    always @(posedge clk) begin
        if (we_s[cap_sel]) wr_q.push_back({addr_s[cap_sel], wd_s[cap_sel]});
    end

    // Reference: walk the March C- algorithm over an array holding the same cell faults.
    function automatic void model_run(input logic [31:0] bg);
        logic [31:0] m [8];
        int dir [6] = '{0, 0, 0, 1, 1, 1};
        int rv  [6] = '{-1, 0, 1, 0, 1, 0};
        int wv  [6] = '{0, 1, 0, 1, 0, -1};
        exp_wr.delete();
        m_pass = 1'b1; m_faddr = '0; m_fexp = '0; m_fgot = '0; m_cyc = 0;
        for (int i = 0; i < 8; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 8; i++) begin
                logic [2:0]  a;
                logic [31:0] v, got;
                a = (dir[e] != 0) ? 3'(7 - i) : 3'(i);
                m_cyc += (rv[e] < 0) ? 1 : 2;
                if (rv[e] >= 0) begin
                    got = cell_read(a, m[a]);
                    v   = (rv[e] != 0) ? ~bg : bg;
                    if (got !== v) begin
                        m_pass = 1'b0; m_faddr = a; m_fexp = v; m_fgot = got;
                        return;
                    end
                end
                if (wv[e] >= 0) begin
                    v = (wv[e] != 0) ? ~bg : bg;
                    exp_wr.push_back({a, v});
                    m[a] = v;
                    if (f_mode == 2 && a == f_a) m[f_b] = v;
                end
            end
        end
    endfunction

    function automatic int seq_diff();
        int n;
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < n; i++) if (wr_q[i] !== exp_wr[i]) return i;
        if (wr_q.size() != exp_wr.size()) return n;
        return -1;
    endfunction

    // Pulse start, count busy cycles until done; cyc = -1 if the bound expires.
    task automatic do_run(input int sel, input int pulse_at, output int cyc);
        int n;
        n = 0;
        cyc = -1;
        cap_sel = sel;
        wr_q.delete();
        @(negedge clk); start_s[sel] = 1'b1;
        @(negedge clk); start_s[sel] = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            if (busy_s[sel]) n++;
            if (done_s[sel]) begin
                cyc = n;
                break;
            end
            start_s[sel] = (n == pulse_at);
            @(negedge clk);
        end
        start_s[sel] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({busy_s[g], done_s[g], pass_s[g], we_s[g], addr_s[g], wd_s[g], faddr_s[g], fexp_s[g], fgot_s[g]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: busy=%b done=%b pass=%b we=%b addr=%h wdata=%h, required all 0",
                         g, busy_s[g], done_s[g], pass_s[g], we_s[g], addr_s[g], wd_s[g]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fault_free();
        int cyc, d;
        f_mode = 0;
        model_run(32'h0);
        do_run(0, -1, cyc);
        d = seq_diff();
        checks++;
        if (cyc !== 88) begin errors++; $display("FAIL ff_busy_cycles: got %0d, required 88", cyc); end
        checks++;
        if ({done_s[0], pass_s[0], busy_s[0]} !== 3'b110) begin
            errors++; $display("FAIL ff_status: done/pass/busy=%b%b%b, required 110", done_s[0], pass_s[0], busy_s[0]);
        end
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL ff_write_seq: first diff at %0d (got %0d writes, required %0d)", d, wr_q.size(), exp_wr.size());
        end
    endtask

    task automatic test_stuck();
        int cyc, d;
        f_mode = 1; f_a = 3'd3; f_bit = 5; f_val = 1'b0;
        model_run(32'h0);
        do_run(0, -1, cyc);
        d = seq_diff();
        checks++;
        if ({done_s[0], pass_s[0]} !== 2'b10) begin
            errors++; $display("FAIL sa_status: done/pass=%b%b, required 10", done_s[0], pass_s[0]);
        end
        checks++;
        if ({faddr_s[0], fexp_s[0], fgot_s[0]} !== {3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFDF}) begin
            errors++; $display("FAIL sa_fail_info: addr=%0d exp=%h got=%h, required 3 FFFFFFFF FFFFFFDF",
                               faddr_s[0], fexp_s[0], fgot_s[0]);
        end
        checks++;
        if (cyc !== m_cyc) begin errors++; $display("FAIL sa_busy_cycles: got %0d, required %0d", cyc, m_cyc); end
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL sa_write_seq: first diff at %0d (got %0d writes, required %0d)", d, wr_q.size(), exp_wr.size());
        end
    endtask

    task automatic test_decoder();
        int cyc, d;
        f_mode = 2; f_a = 3'd6; f_b = 3'd2;
        model_run(32'h0);
        do_run(0, -1, cyc);
        d = seq_diff();
        checks++;
        if ({done_s[0], pass_s[0]} !== 2'b10) begin
            errors++; $display("FAIL af_status: done/pass=%b%b, required 10", done_s[0], pass_s[0]);
        end
        checks++;
        if ({faddr_s[0], fexp_s[0], fgot_s[0]} !== {3'd2, 32'h0000_0000, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL af_fail_info: addr=%0d exp=%h got=%h, required 2 00000000 FFFFFFFF",
                               faddr_s[0], fexp_s[0], fgot_s[0]);
        end
        checks++;
        if (cyc !== m_cyc) begin errors++; $display("FAIL af_busy_cycles: got %0d, required %0d", cyc, m_cyc); end
        checks++;
        if (d != -1) begin
            errors++; $display("FAIL af_write_seq: first diff at %0d (got %0d writes, required %0d)", d, wr_q.size(), exp_wr.size());
        end
    endtask

    task automatic test_background();
        int cyc, bad;
        f_mode = 0;
        model_run(32'h5555_5555);
        do_run(1, -1, cyc);
        checks++;
        if (cyc !== 88 || pass_s[1] !== 1'b1) begin
            errors++; $display("FAIL bg_run: busy=%0d pass=%b, required 88 1", cyc, pass_s[1]);
        end
        // E3 writes follow its reads: 8 (E0) + 8 (E1) + 8 (E2) earlier writes
        bad = -1;
        for (int i = 0; i < 8; i++) begin
            if (wr_q.size() < 32 || wr_q[24 + i] !== {3'(7 - i), 32'hAAAA_AAAA}) begin
                bad = i;
                break;
            end
        end
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL bg_e3_descending: step %0d wrong (writes=%0d), required addr %0d data AAAAAAAA",
                               bad, wr_q.size(), 7 - bad);
        end
        checks++;
        if (seq_diff() != -1) begin
            errors++; $display("FAIL bg_write_seq: first diff at %0d", seq_diff());
        end
    endtask

    task automatic test_start_reset();
        int cyc, n;
        f_mode = 0;
        model_run(32'h0);
        do_run(0, 10, cyc);
        checks++;
        if (cyc !== 88 || pass_s[0] !== 1'b1) begin
            errors++; $display("FAIL sr_ignored_start: busy=%0d pass=%b, required 88 1", cyc, pass_s[0]);
        end
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        n = 0;
        for (int t = 0; t < 200 && n < 40; t++) begin
            if (busy_s[0]) n++;
            if (n < 40) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_s[0], done_s[0], pass_s[0], we_s[0], addr_s[0], wd_s[0], faddr_s[0], fexp_s[0], fgot_s[0]} !== '0 || n != 40) begin
            errors++; $display("FAIL sr_mid_reset: cyc=%0d busy=%b done=%b we=%b addr=%h wdata=%h, required 40 and all 0",
                               n, busy_s[0], done_s[0], we_s[0], addr_s[0], wd_s[0]);
        end
        @(negedge clk); rst_n = 1'b1;
        do_run(0, -1, cyc);
        checks++;
        if (cyc !== 88 || pass_s[0] !== 1'b1 || seq_diff() != -1) begin
            errors++; $display("FAIL sr_restart: busy=%0d pass=%b seqdiff=%0d, required 88 1 -1", cyc, pass_s[0], seq_diff());
        end
    endtask

    task automatic test_back_to_back();
        int n, cyc;
        f_mode = 0;
        n = 0; cyc = -1;
        @(negedge clk); start_s[0] = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 2000; t++) begin
            if (busy_s[0]) n++;
            if (done_s[0]) begin cyc = n; break; end
            @(negedge clk);
        end
        checks++;
        if (cyc !== 88 || busy_s[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_first_run: busy=%0d busy_now=%b, required 88 0", cyc, busy_s[0]);
        end
        @(negedge clk);
        start_s[0] = 1'b0;
        checks++;
        if ({busy_s[0], done_s[0]} !== 2'b10) begin
            errors++; $display("FAIL b2b_restart: busy/done=%b%b, required 10", busy_s[0], done_s[0]);
        end
        n = 0; cyc = -1;
        for (int t = 0; t < 2000; t++) begin
            if (busy_s[0]) n++;
            if (done_s[0]) begin cyc = n; break; end
            @(negedge clk);
        end
        checks++;
        if (cyc !== 88 || pass_s[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_second_run: busy=%0d pass=%b, required 88 1", cyc, pass_s[0]);
        end
    endtask

    task automatic test_random();
        int cyc, sel, d;
        for (int it = 0; it < 8; it++) begin
            sel    = int'($urandom_range(0, 1));
            f_mode = int'($urandom_range(0, 2));
            f_a    = 3'($urandom_range(0, 7));
            f_b    = f_a + 3'($urandom_range(1, 7));
            f_bit  = int'($urandom_range(0, 31));
            f_val  = 1'($urandom_range(0, 1));
            model_run((sel != 0) ? 32'h5555_5555 : 32'h0);
            do_run(sel, -1, cyc);
            d = seq_diff();
            checks++;
            if (cyc !== m_cyc || pass_s[sel] !== m_pass) begin
                errors++; $display("FAIL rnd%0d_run: mode=%0d busy=%0d pass=%b, required %0d %b",
                                   it, f_mode, cyc, pass_s[sel], m_cyc, m_pass);
            end
            if (!m_pass) begin
                checks++;
                if ({faddr_s[sel], fexp_s[sel], fgot_s[sel]} !== {m_faddr, m_fexp, m_fgot}) begin
                    errors++; $display("FAIL rnd%0d_fail_info: addr=%0d exp=%h got=%h, required %0d %h %h",
                                       it, faddr_s[sel], fexp_s[sel], fgot_s[sel], m_faddr, m_fexp, m_fgot);
                end
            end
            checks++;
            if (d != -1) begin
                errors++; $display("FAIL rnd%0d_write_seq: first diff at %0d (got %0d writes, required %0d)",
                                   it, d, wr_q.size(), exp_wr.size());
            end
        end
    endtask

    initial begin
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck();
        test_decoder();
        test_background();
        test_start_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
